// File: rtl/ahb_apb_bridge.sv
//==============================================================================
// Module   : ahb_apb_bridge
// Brief    : AHB slave to APB3/APB4 bridge, one outstanding transfer, PS_NUM
//            peripherals decoded from HADDR[DEC_LSB+:4]. Define APB_TIMEOUT_EN
//            to abort ACCESS phases that wait TMO_CYC cycles for PREADY.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ahb_apb_bridge #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int PS_NUM  = 4,
    parameter int DEC_LSB = 12,
    parameter int TMO_CYC = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESETN,
    input  logic                 HSEL,
    input  logic [AW-1:0]        HADDR,
    input  logic [1:0]           HTRANS,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [2:0]           HBURST,
    input  logic [DW/8-1:0]      HWSTRB,
    input  logic [DW-1:0]        HWDATA,
    input  logic                 HREADY,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [DW-1:0]        HRDATA,
    output logic [AW-1:0]        PADDR,
    output logic [PS_NUM-1:0]    PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [DW-1:0]        PWDATA,
    output logic [DW/8-1:0]      PSTRB,
    input  logic [PS_NUM*DW-1:0] PRDATA,
    input  logic [PS_NUM-1:0]    PREADY,
    input  logic [PS_NUM-1:0]    PSLVERR
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDAT   = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    state_t              r_state;
    logic [PS_NUM-1:0]   r_sel;
    logic [3:0]          w_hidx;
    logic [PS_NUM-1:0]   w_dec;
    logic                w_hit;
    logic                w_accept;
    logic                w_pready;
    logic                w_pslverr;
    logic [DW-1:0]       w_prdata;
    logic                w_unused_ok;

    // Burst and size information plays no role: each beat is a full-width APB access.
    assign w_unused_ok = &{1'b0, HSIZE, HBURST, HTRANS[0], (TMO_CYC > 0)};

    assign w_hidx   = HADDR[DEC_LSB +: 4];
    assign w_accept = HSEL & HREADY & HTRANS[1];
    assign w_hit    = |w_dec;

    always_comb begin
        w_dec = '0;
        for (int i = 0; i < PS_NUM; i++) begin
            w_dec[i] = (w_hidx == 4'(i));
        end
    end

    // Peripheral responses are picked through the latched one-hot select.
    assign w_pready  = |(PREADY & r_sel);
    assign w_pslverr = |(PSLVERR & r_sel);

    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < PS_NUM; i++) begin
            if (r_sel[i]) begin
                w_prdata = w_prdata | PRDATA[i*DW +: DW];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int                c_TW       = $clog2(TMO_CYC + 1);
    localparam logic [c_TW-1:0]   c_TMO_LAST = c_TW'(TMO_CYC - 1);
    localparam logic [c_TW-1:0]   c_TMO_FULL = c_TW'(TMO_CYC);
    logic [c_TW-1:0]              r_tmo;
`endif

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PADDR     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSTRB     <= '0;
`ifdef APB_TIMEOUT_EN
            r_tmo     <= '0;
`endif
        end else begin
            case (r_state)
                // DONE and ERR2 are the last data-phase cycle, so a pipelined
                // address phase is taken here exactly as in IDLE.
                S_IDLE, S_DONE, S_ERR2: begin
                    r_state   <= S_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (w_accept) begin
                        PADDR     <= HADDR;
                        PWRITE    <= HWRITE;
                        r_sel     <= w_dec;
                        HREADYOUT <= 1'b0;
                        if (!w_hit) begin
                            r_state <= S_ERR1;
                            HRESP   <= 1'b1;
                        end else if (HWRITE) begin
                            r_state <= S_WDAT;
                        end else begin
                            r_state <= S_SETUP;
                            PSEL    <= w_dec;
                            PSTRB   <= '0;
                        end
                    end
                end
                S_WDAT: begin
                    PWDATA  <= HWDATA;
                    PSTRB   <= HWSTRB;
                    PSEL    <= r_sel;
                    r_state <= S_SETUP;
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_tmo   <= '0;
`endif
                end
                S_ACCESS: begin
                    if (w_pready) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        if (w_pslverr) begin
                            r_state <= S_ERR1;
                            HRESP   <= 1'b1;
                        end else begin
                            r_state   <= S_DONE;
                            HREADYOUT <= 1'b1;
                            if (!PWRITE) begin
                                HRDATA <= w_prdata;
                            end
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_tmo == c_TMO_LAST) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        r_state <= S_ERR1;
                        HRESP   <= 1'b1;
                        r_tmo   <= c_TMO_FULL;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
`endif
                end
                S_ERR1: begin
                    HREADYOUT <= 1'b1;
                    r_state   <= S_ERR2;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_apb_bridge.sv
//==============================================================================
// Module   : tb_ahb_apb_bridge
// Brief    : Scoreboard bench for ahb_apb_bridge (AHB master + APB peripheral model).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ahb_apb_bridge;

    localparam int c_DW = 32;
    localparam int c_PS = 4;

    logic                 HCLK = 1'b0;
    logic                 HRESETN;
    logic                 HSEL;
    logic [31:0]          HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [2:0]           HBURST;
    logic [3:0]           HWSTRB;
    logic [31:0]          HWDATA;
    logic                 HREADY;
    logic                 HREADYOUT;
    logic                 HRESP;
    logic [31:0]          HRDATA;
    logic [31:0]          PADDR;
    logic [c_PS-1:0]      PSEL;
    logic                 PENABLE;
    logic                 PWRITE;
    logic [31:0]          PWDATA;
    logic [3:0]           PSTRB;
    logic [c_PS*c_DW-1:0] PRDATA;
    logic [c_PS-1:0]      PREADY;
    logic [c_PS-1:0]      PSLVERR;

    assign HREADY = HREADYOUT;

    ahb_apb_bridge #(
        .AW(32), .DW(c_DW), .PS_NUM(c_PS), .DEC_LSB(12), .TMO_CYC(8)
    ) u_dut (
        .HCLK(HCLK), .HRESETN(HRESETN), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HWSTRB(HWSTRB), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    // APB peripheral model: PREADY rises after apb_wait ACCESS cycles.
    int          apb_wait = 0;
    logic        apb_err  = 1'b0;
    logic [31:0] prd [c_PS];
    int          acc_cnt  = 0;

    always @(posedge HCLK) begin
        if (PSEL != '0 && PENABLE) acc_cnt <= acc_cnt + 1;
        else                       acc_cnt <= 0;
    end

    assign PREADY  = {c_PS{acc_cnt >= apb_wait}};
    assign PSLVERR = {c_PS{apb_err}};

    for (genvar g = 0; g < c_PS; g++) begin : g_prd
        assign PRDATA[g*c_DW +: c_DW] = prd[g];
    end

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } ahb_exp_t;

    typedef struct {
        logic [3:0]  psel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_exp_t;

    ahb_exp_t    ahb_q[$];
    apb_exp_t    apb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rd  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // APB monitor: SETUP pops the expected transaction, ACCESS must hold it stable.
    apb_exp_t    mon_e;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_strb, cap_psel;
    logic        cap_wr;

    always @(negedge HCLK) begin
        if (HRESETN) begin
            if (PSEL != '0) check("psel_onehot", 64'($onehot(PSEL)), 1);
            if (PENABLE)    check("penable_has_psel", 64'(PSEL != '0), 1);
            if (PSEL != '0 && !PENABLE) begin
                check("apb_setup_expected", 64'(apb_q.size() != 0), 1);
                if (apb_q.size() != 0) begin
                    mon_e = apb_q.pop_front();
                    check("apb_psel", PSEL, mon_e.psel);
                    check("apb_paddr", PADDR, mon_e.addr);
                    check("apb_pwrite", PWRITE, mon_e.wr);
                    check("apb_pstrb", PSTRB, mon_e.strb);
                    if (mon_e.wr) check("apb_pwdata", PWDATA, mon_e.wdata);
                end
                cap_addr  = PADDR;
                cap_wdata = PWDATA;
                cap_strb  = PSTRB;
                cap_psel  = PSEL;
                cap_wr    = PWRITE;
            end
            if (PENABLE) begin
                check("apb_stable_paddr", PADDR, cap_addr);
                check("apb_stable_pwdata", PWDATA, cap_wdata);
                check("apb_stable_pstrb", PSTRB, cap_strb);
                check("apb_stable_psel", PSEL, cap_psel);
                check("apb_stable_pwrite", PWRITE, cap_wr);
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_hreadyout"}, HREADYOUT, 1);
        check({tag, "_hresp"}, HRESP, 0);
        check({tag, "_hrdata"}, HRDATA, 0);
        check({tag, "_psel"}, PSEL, 0);
        check({tag, "_penable"}, PENABLE, 0);
        check({tag, "_paddr"}, PADDR, 0);
        check({tag, "_pwrite"}, PWRITE, 0);
        check({tag, "_pwdata"}, PWDATA, 0);
        check({tag, "_pstrb"}, PSTRB, 0);
    endtask

    // One AHB transfer; called at a negedge with HREADY high, returns at the
    // negedge of the final data-phase cycle so a next call is back-to-back.
    task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] st, input int wt, input logic err,
                            input logic tmo = 1'b0);
        ahb_exp_t   e;
        apb_exp_t   a;
        logic [3:0] idx;
        int         waits;
        logic       prev_resp;
        idx = addr[15:12];
        if (idx <= 4'd3) begin
            a.psel  = 4'b0001 << idx;
            a.addr  = addr;
            a.wr    = wr;
            a.wdata = wd;
            a.strb  = wr ? st : 4'b0000;
            apb_q.push_back(a);
            if (tmo) begin
                e.waits = (wr ? 1 : 0) + 1 + 8 + 1;
                e.resp  = 1'b1;
            end else begin
                e.waits = (wr ? 1 : 0) + 1 + (wt + 1) + (err ? 1 : 0);
                e.resp  = err;
                if (!wr && !err) last_rd = prd[idx[1:0]];
            end
        end else begin
            e.waits = 1;
            e.resp  = 1'b1;
        end
        e.rdata = last_rd;
        ahb_q.push_back(e);
        apb_wait = wt;
        apb_err  = err;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        @(negedge HCLK);
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = wd;
        HWSTRB = st;
        waits     = 0;
        prev_resp = 1'b0;
        while (!HREADYOUT && waits < 40) begin
            prev_resp = HRESP;
            waits++;
            @(negedge HCLK);
        end
        e = ahb_q.pop_front();
        check("ahb_wait_cycles", 64'(waits), 64'(e.waits));
        check("ahb_resp_first", prev_resp, e.resp);
        check("ahb_resp_last", HRESP, e.resp);
        check("ahb_hrdata", HRDATA, e.rdata);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        apb_exp_t ra;
        HRESETN = 1'b0;
        HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HSIZE = 3'b010; HBURST = 3'b000; HWSTRB = '0; HWDATA = '0;
        for (int i = 0; i < c_PS; i++) prd[i] = 32'h1111_0000 + 32'(i);
        repeat (2) @(negedge HCLK);
        check_reset("por");
        HRESETN = 1'b1;
        @(negedge HCLK);

        // IDLE and BUSY with HSEL: zero-wait OKAY, no APB activity
        HSEL = 1'b1; HTRANS = 2'b01; HADDR = 32'h0000_1000;
        @(negedge HCLK);
        check("busy_hreadyout", HREADYOUT, 1);
        check("busy_hresp", HRESP, 0);
        check("busy_psel", PSEL, 0);
        HTRANS = 2'b00;
        @(negedge HCLK);
        check("idle_hreadyout", HREADYOUT, 1);
        check("idle_hresp", HRESP, 0);
        check("idle_psel", PSEL, 0);
        HSEL = 1'b0;
        @(negedge HCLK);

        // T1 read, T2 write with wait states, T3 slave error, T4 decode miss
        prd[1] = 32'hDEAD_BEEF;
        ahb_xfer(32'h0000_1004, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        @(negedge HCLK);
        ahb_xfer(32'h0000_2008, 1'b1, 32'h1234_5678, 4'b0011, 3, 1'b0);
        @(negedge HCLK);
        ahb_xfer(32'h0000_0010, 1'b0, 32'h0, 4'h0, 0, 1'b1);
        @(negedge HCLK);
        ahb_xfer(32'h0000_7000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        @(negedge HCLK);

        // T5 back-to-back: accepts in DONE and in ERR2
        prd[3] = 32'h3333_ABCD;
        prd[0] = 32'h0000_C0DE;
        ahb_xfer(32'h0000_3000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        ahb_xfer(32'h0000_2100, 1'b1, 32'hFEED_F00D, 4'b1100, 1, 1'b0);
        ahb_xfer(32'h0000_0200, 1'b0, 32'h0, 4'h0, 2, 1'b0);
        ahb_xfer(32'h0000_5000, 1'b1, 32'h0, 4'hF, 0, 1'b0);
        ahb_xfer(32'h0000_1300, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        @(negedge HCLK);

        for (int k = 0; k < 8; k++) begin
            logic [31:0] ad;
            logic        w;
            int          wt;
            ad = 32'(($urandom_range(0, 3) << 12) | ($urandom_range(0, 63) << 2));
            w  = 1'($urandom_range(0, 1));
            wt = int'($urandom_range(0, 2));
            prd[ad[13:12]] = $urandom;
            ahb_xfer(ad, w, $urandom, 4'($urandom_range(1, 15)), wt, 1'b0);
        end
        @(negedge HCLK);

`ifdef APB_TIMEOUT_EN
        ahb_xfer(32'h0000_2040, 1'b0, 32'h0, 4'h0, 1000, 1'b0, 1'b1);
        check("tmo_psel_dropped", PSEL, 0);
        apb_wait = 0;
        @(negedge HCLK);
`endif

        // Asynchronous reset in the middle of an ACCESS phase
        apb_wait  = 1000;
        apb_err   = 1'b0;
        ra.psel   = 4'b0010;
        ra.addr   = 32'h0000_1010;
        ra.wr     = 1'b1;
        ra.wdata  = 32'hA5A5_5A5A;
        ra.strb   = 4'b1111;
        apb_q.push_back(ra);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_1010; HWRITE = 1'b1;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hA5A5_5A5A; HWSTRB = 4'b1111;
        repeat (3) @(negedge HCLK);
        check("pre_rst_penable", PENABLE, 1);
        check("pre_rst_hreadyout", HREADYOUT, 0);
        #2 HRESETN = 1'b0;
        #1 check_reset("midrst");
        @(negedge HCLK);
        HRESETN  = 1'b1;
        apb_wait = 0;
        last_rd  = '0;
        @(negedge HCLK);
        ahb_xfer(32'h0000_6000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        prd[2] = 32'h0BAD_CAFE;
        ahb_xfer(32'h0000_2000, 1'b0, 32'h0, 4'h0, 1, 1'b0);

        repeat (3) @(negedge HCLK);
        check("ahb_q_drained", 64'(ahb_q.size()), 0);
        check("apb_q_drained", 64'(apb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
